// File: rtl/idma_req_queue.sv
// idma_req_queue
//   Buffering stage between the iDMA register frontend and the backend.
//   Requests are stored in an in-order circular FIFO and forwarded to the
//   backend. Issue stops while MaxOutstanding transfers are in flight.
//   Completions are counted and turned into a registered completion pulse.
//
// Optional feature: define IDMA_REQ_QUEUE_STATS_EN to enable the 32-bit
//   saturating issued/retired statistics counters. When it is undefined,
//   num_issued_o and num_retired_o are tied to zero.
//
// Ports:
//   clk_i, rst_ni      clock, asynchronous active-low reset
//   req_i/_valid_i     request from the frontend
//   req_ready_o        the queue can accept a request
//   req_o/_valid_o     head request toward the backend
//   req_ready_i        the backend accepts the head request
//   rsp_valid_i        the backend finished one transfer (one pulse each)
//   backend_idle_i     the backend reports idle
//   trans_complete_o   one-cycle completion pulse toward the frontend
//   idle_o             queue empty, nothing outstanding, backend idle
//   outstanding_o      transfers issued and not yet completed
//   num_issued_o       statistics: total pops
//   num_retired_o      statistics: total accepted completions
module idma_req_queue #(
  parameter type         burst_req_t    = logic,
  parameter int unsigned Depth          = 4,
  parameter int unsigned MaxOutstanding = 8,
  parameter int unsigned OutCntWidth    = $clog2(MaxOutstanding + 1)
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  burst_req_t             req_i,
  input  logic                   req_valid_i,
  output logic                   req_ready_o,
  output burst_req_t             req_o,
  output logic                   req_valid_o,
  input  logic                   req_ready_i,
  input  logic                   rsp_valid_i,
  input  logic                   backend_idle_i,
  output logic                   trans_complete_o,
  output logic                   idle_o,
  output logic [OutCntWidth-1:0] outstanding_o,
  output logic [31:0]            num_issued_o,
  output logic [31:0]            num_retired_o
);

  localparam int unsigned PtrWidth   = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned UsageWidth = $clog2(Depth + 1);

  localparam logic [PtrWidth-1:0]    PtrLast   = PtrWidth'(Depth - 1);
  localparam logic [PtrWidth-1:0]    PtrOne    = PtrWidth'(1);
  localparam logic [UsageWidth-1:0]  UsageFull = UsageWidth'(Depth);
  localparam logic [UsageWidth-1:0]  UsageOne  = UsageWidth'(1);
  localparam logic [OutCntWidth-1:0] OutMax    = OutCntWidth'(MaxOutstanding);
  localparam logic [OutCntWidth-1:0] OutOne    = OutCntWidth'(1);

  burst_req_t               r_mem [Depth];
  logic [PtrWidth-1:0]      r_wr_ptr;
  logic [PtrWidth-1:0]      r_rd_ptr;
  logic [UsageWidth-1:0]    r_usage;
  logic [OutCntWidth-1:0]   r_outstanding;
  logic                     r_trans_complete;

  logic                     w_push;
  logic                     w_pop;
  logic                     w_rsp_acc;

  // Readiness depends only on the current fill level, so a full queue
  // refuses a push even when the head leaves in the same cycle.
  assign req_ready_o = (r_usage != UsageFull);
  assign req_valid_o = (r_usage != '0) && (r_outstanding < OutMax);
  assign req_o       = r_mem[r_rd_ptr];

  assign w_push = req_valid_i && req_ready_o;
  assign w_pop  = req_valid_o && req_ready_i;
  // A completion with nothing in flight is only legitimate when a pop
  // happens in the same cycle; otherwise it is a stray (e.g. after reset).
  assign w_rsp_acc = rsp_valid_i && ((r_outstanding != '0) || w_pop);

  // One register per entry, written only when the write pointer selects it.
  for (genvar gi = 0; gi < Depth; gi++) begin : g_entry
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        r_mem[gi] <= '0;
      end else if (w_push && (r_wr_ptr == PtrWidth'(gi))) begin
        r_mem[gi] <= req_i;
      end
    end
  end

  // Pointers wrap explicitly so Depth need not be a power of two.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_usage  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= (r_wr_ptr == PtrLast) ? '0 : r_wr_ptr + PtrOne;
      end
      if (w_pop) begin
        r_rd_ptr <= (r_rd_ptr == PtrLast) ? '0 : r_rd_ptr + PtrOne;
      end
      if (w_push && !w_pop) begin
        r_usage <= r_usage + UsageOne;
      end else if (!w_push && w_pop) begin
        r_usage <= r_usage - UsageOne;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_outstanding    <= '0;
      r_trans_complete <= 1'b0;
    end else begin
      r_trans_complete <= w_rsp_acc;
      if (w_pop && !w_rsp_acc) begin
        r_outstanding <= r_outstanding + OutOne;
      end else if (!w_pop && w_rsp_acc) begin
        r_outstanding <= r_outstanding - OutOne;
      end
    end
  end

  assign trans_complete_o = r_trans_complete;
  assign outstanding_o    = r_outstanding;
  assign idle_o           = (r_usage == '0) && (r_outstanding == '0) && backend_idle_i;

`ifdef IDMA_REQ_QUEUE_STATS_EN
  logic [31:0] r_num_issued;
  logic [31:0] r_num_retired;

  // Saturating counters: they stick at all-ones instead of wrapping.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_num_issued  <= '0;
      r_num_retired <= '0;
    end else begin
      if (w_pop && (r_num_issued != '1)) begin
        r_num_issued <= r_num_issued + 32'd1;
      end
      if (w_rsp_acc && (r_num_retired != '1)) begin
        r_num_retired <= r_num_retired + 32'd1;
      end
    end
  end

  assign num_issued_o  = r_num_issued;
  assign num_retired_o = r_num_retired;
`else
  assign num_issued_o  = '0;
  assign num_retired_o = '0;
`endif

endmodule

// File: tb/tb_idma_req_queue.sv
module tb_idma_req_queue;

  localparam int DEPTH = 4;
  localparam int MAXO  = 2;
`ifdef IDMA_REQ_QUEUE_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  typedef logic [15:0] req_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  req_t       req_i = '0;
  logic       req_valid_i = 1'b0;
  logic       req_ready_o;
  req_t       req_o;
  logic       req_valid_o;
  logic       req_ready_i = 1'b0;
  logic       rsp_valid_i = 1'b0;
  logic       backend_idle_i = 1'b1;
  logic       trans_complete_o;
  logic       idle_o;
  logic [1:0] outstanding_o;
  logic [31:0] num_issued_o;
  logic [31:0] num_retired_o;

  always #5 clk = ~clk;

  idma_req_queue #(
    .burst_req_t   (req_t),
    .Depth         (DEPTH),
    .MaxOutstanding(MAXO)
  ) u_dut (
    .clk_i           (clk),
    .rst_ni          (rst_n),
    .req_i           (req_i),
    .req_valid_i     (req_valid_i),
    .req_ready_o     (req_ready_o),
    .req_o           (req_o),
    .req_valid_o     (req_valid_o),
    .req_ready_i     (req_ready_i),
    .rsp_valid_i     (rsp_valid_i),
    .backend_idle_i  (backend_idle_i),
    .trans_complete_o(trans_complete_o),
    .idle_o          (idle_o),
    .outstanding_o   (outstanding_o),
    .num_issued_o    (num_issued_o),
    .num_retired_o   (num_retired_o)
  );

  int checks = 0;
  int errors = 0;

  // Reference model / scoreboard
  req_t exp_q[$];
  int   m_out = 0;
  logic m_tc = 1'b0;
  int   m_issued = 0;
  int   m_retired = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    logic exp_valid;
    exp_valid = (exp_q.size() != 0) && (m_out < MAXO);
    chk("req_ready", req_ready_o, (exp_q.size() < DEPTH));
    chk("req_valid", req_valid_o, exp_valid);
    if (exp_valid) chk("req_data", req_o, exp_q[0]);
    chk("outstanding", outstanding_o, m_out);
    chk("trans_complete", trans_complete_o, m_tc);
    chk("idle", idle_o, (exp_q.size() == 0) && (m_out == 0) && backend_idle_i);
    chk("num_issued", num_issued_o, STATS ? m_issued : 0);
    chk("num_retired", num_retired_o, STATS ? m_retired : 0);
  endtask

  // One clock cycle: drive inputs on the falling edge, check outputs against
  // the model, then advance the model to the state after the rising edge.
  task automatic step(input logic push, input req_t data, input logic rdy,
                      input logic rsp, output logic accepted);
    logic exp_valid, do_pop, acc;
    @(negedge clk);
    req_valid_i = push;
    req_i       = data;
    req_ready_i = rdy;
    rsp_valid_i = rsp;
    #1;
    check_outputs();
    exp_valid = (exp_q.size() != 0) && (m_out < MAXO);
    do_pop    = exp_valid && rdy;
    accepted  = push && (exp_q.size() < DEPTH);
    acc       = rsp && ((m_out != 0) || do_pop);
    if (push || do_pop || rsp)
      $display("t=%0t push=%0b data=%h accepted=%0b pop=%0b pop_data=%h rsp=%0b rsp_accepted=%0b",
               $time, push, data, accepted, do_pop, req_o, rsp, acc);
    if (do_pop) begin
      void'(exp_q.pop_front());
      m_out++;
      m_issued++;
    end
    if (accepted) exp_q.push_back(data);
    if (acc) begin
      m_out--;
      m_retired++;
    end
    m_tc = acc;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n       = 1'b0;
    req_valid_i = 1'b0;
    req_ready_i = 1'b0;
    rsp_valid_i = 1'b0;
    #1;
    // Asynchronous reset: outputs settle without waiting for a clock edge.
    chk("rst_req_ready", req_ready_o, 1);
    chk("rst_req_valid", req_valid_o, 0);
    chk("rst_trans_complete", trans_complete_o, 0);
    chk("rst_outstanding", outstanding_o, 0);
    chk("rst_idle", idle_o, backend_idle_i);
    chk("rst_num_issued", num_issued_o, 0);
    chk("rst_num_retired", num_retired_o, 0);
    $display("t=%0t reset asserted", $time);
    exp_q.delete();
    m_out = 0;
    m_tc = 1'b0;
    m_issued = 0;
    m_retired = 0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic acc;
    logic pend;
    int   retry_k;
    int   pushed;

    backend_idle_i = 1'b1;
    do_reset();
    step(0, '0, 0, 0, acc);

    // Single request: push, pop next cycle, complete later.
    step(1, 16'hA001, 1, 0, acc);
    backend_idle_i = 1'b0;
    step(0, '0, 1, 0, acc);
    step(0, '0, 1, 0, acc);
    chk("single_out", outstanding_o, 1);
    step(0, '0, 1, 0, acc);
    step(0, '0, 1, 1, acc);
    step(0, '0, 1, 0, acc);
    backend_idle_i = 1'b1;
    step(0, '0, 1, 0, acc);
    chk("single_idle", idle_o, 1);

    // Fill with backend stalled: the 5th push must be refused.
    for (int i = 0; i < 5; i++) begin
      step(1, req_t'(16'hB000 + i), 0, 0, acc);
      if (i == 4) chk("fill_5th_refused", acc, 0);
    end
    chk("fill_full_ready", req_ready_o, 0);
    // Drain while retrying the 5th request; completions keep up with pops.
    pend = 1'b1;
    retry_k = -1;
    for (int k = 0; k < 12; k++) begin
      step(pend, 16'hB004, 1, 1, acc);
      if (acc && pend) begin
        retry_k = k;
        pend = 1'b0;
      end
    end
    chk("fill_retry_cycle", retry_k, 1);
    step(0, '0, 0, 0, acc);

    // Outstanding limit of 2.
    for (int i = 0; i < 3; i++) step(1, req_t'(16'hC000 + i), 0, 0, acc);
    step(0, '0, 1, 0, acc);
    step(0, '0, 1, 0, acc);
    step(0, '0, 1, 0, acc);
    chk("limit_stall_valid", req_valid_o, 0);
    step(0, '0, 1, 1, acc);
    step(0, '0, 1, 0, acc);
    step(0, '0, 1, 0, acc);
    chk("limit_out_stays2", outstanding_o, 2);
    step(0, '0, 0, 1, acc);

    // Simultaneous pop and completion at outstanding 1.
    step(1, 16'hD000, 0, 0, acc);
    step(0, '0, 1, 1, acc);
    step(0, '0, 0, 0, acc);
    chk("simul_tc", trans_complete_o, 1);
    chk("simul_out", outstanding_o, 1);
    step(0, '0, 0, 1, acc);
    step(0, '0, 0, 0, acc);

    // Spurious completion with nothing outstanding.
    step(0, '0, 0, 1, acc);
    step(0, '0, 0, 0, acc);
    chk("spurious_tc", trans_complete_o, 0);

    // Reset with three entries queued, then a stale completion.
    for (int i = 0; i < 3; i++) step(1, req_t'(16'hE000 + i), 0, 0, acc);
    do_reset();
    step(0, '0, 0, 1, acc);
    step(0, '0, 0, 0, acc);
    chk("post_rst_tc", trans_complete_o, 0);

    // Six transfers issued and completed, for the statistics counters.
    pushed = 0;
    for (int k = 0; k < 20; k++) begin
      step(pushed < 6, req_t'(16'hF000 + pushed), 1, m_out > 0, acc);
      if (acc) pushed++;
    end
    step(0, '0, 0, 0, acc);
    chk("stats_issued", num_issued_o, STATS ? 6 : 0);
    chk("stats_retired", num_retired_o, STATS ? 6 : 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
